// File: rtl/rtc_read.sv
// Read engine for the 3-wire RTC: reads seconds then minutes over ce/sclk/io
// and presents the four BCD digits, the clock-halt bit and a BCD error flag.
module rtc_read #(
  parameter int         HALF    = 2,
  parameter logic [7:0] CMD_SEC = 8'h81,
  parameter logic [7:0] CMD_MIN = 8'h83
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       io_in,
  output logic       ce,
  output logic       sclk,
  output logic       io_out,
  output logic       io_oe,
  output logic       busy,
  output logic       valid,
  output logic [3:0] data_sec_0,
  output logic [3:0] data_sec_1,
  output logic [3:0] data_min_0,
  output logic [3:0] data_min_1,
  output logic       ch,
  output logic       bcd_err
);
  typedef enum logic [1:0] {IDLE, CMD, RD, GAP} state_t;

  localparam int            CW    = $clog2(2*HALF) + 1;
  localparam logic [CW-1:0] HI_AT = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST  = CW'(2*HALF - 1);

  state_t        state_q, state_d;
  logic          t_q, t_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d, sec_q, sec_d;
  logic          ce_q, ce_d, sclk_q, sclk_d, io_out_q, io_out_d, io_oe_q, io_oe_d;
  logic          busy_q, busy_d, valid_q, valid_d, ch_q, ch_d, err_q, err_d;
  logic [3:0]    s0_q, s0_d, s1_q, s1_d, m0_q, m0_d, m1_q, m1_d;

  logic       end_per, hi_edge, last_bit;
  logic [7:0] cmd;
  logic [3:0] n_s0, n_s1, n_m0, n_m1;

  assign end_per  = (cnt_q == LAST);
  assign hi_edge  = (cnt_q == HI_AT);
  assign last_bit = (bit_q == 3'd7);
  assign cmd      = t_q ? CMD_MIN : CMD_SEC;
  // At completion sh_q holds the finished minutes byte.
  assign n_s0 = sec_q[3:0];
  assign n_s1 = {1'b0, sec_q[6:4]};
  assign n_m0 = sh_q[3:0];
  assign n_m1 = {1'b0, sh_q[6:4]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;   t_q     <= 1'b0;  cnt_q  <= '0;    bit_q   <= '0;
      sh_q    <= '0;     sec_q   <= '0;    ce_q   <= 1'b0;  sclk_q  <= 1'b0;
      io_out_q <= 1'b0;  io_oe_q <= 1'b0;  busy_q <= 1'b0;  valid_q <= 1'b0;
      ch_q    <= 1'b0;   err_q   <= 1'b0;
      s0_q <= '0; s1_q <= '0; m0_q <= '0; m1_q <= '0;
    end else begin
      state_q <= state_d;  t_q     <= t_d;     cnt_q  <= cnt_d;   bit_q   <= bit_d;
      sh_q    <= sh_d;     sec_q   <= sec_d;   ce_q   <= ce_d;    sclk_q  <= sclk_d;
      io_out_q <= io_out_d; io_oe_q <= io_oe_d; busy_q <= busy_d; valid_q <= valid_d;
      ch_q    <= ch_d;     err_q   <= err_d;
      s0_q <= s0_d; s1_q <= s1_d; m0_q <= m0_d; m1_q <= m1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CMD;
      CMD:  if (end_per && last_bit) state_d = RD;
      RD:   if (end_per && last_bit) state_d = t_q ? IDLE : GAP;
      GAP:  if (end_per) state_d = CMD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t_d = t_q;  cnt_d = end_per ? '0 : cnt_q + CW'(1);  bit_d = bit_q;
    sh_d = sh_q;  sec_d = sec_q;  ce_d = ce_q;  sclk_d = sclk_q;
    io_out_d = io_out_q;  io_oe_d = io_oe_q;  busy_d = busy_q;  valid_d = 1'b0;
    ch_d = ch_q;  err_d = err_q;
    s0_d = s0_q; s1_d = s1_q; m0_d = m0_q; m1_d = m1_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          t_d = 1'b0; bit_d = '0; ce_d = 1'b1; io_oe_d = 1'b1;
          io_out_d = CMD_SEC[0]; busy_d = 1'b1;
        end
      end
      CMD: begin
        if (hi_edge) sclk_d = 1'b1;
        if (end_per) begin
          sclk_d = 1'b0;
          if (last_bit) begin
            bit_d = '0; io_oe_d = 1'b0; io_out_d = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1; io_out_d = cmd[bit_q + 3'd1];
          end
        end
      end
      RD: begin
        if (hi_edge) begin
          sclk_d = 1'b1;
          sh_d   = {io_in, sh_q[7:1]};
        end
        if (end_per) begin
          sclk_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          if (last_bit) begin
            ce_d = 1'b0;
            if (t_q) begin
              s0_d = n_s0; s1_d = n_s1; m0_d = n_m0; m1_d = n_m1;
              ch_d = sec_q[7];
              err_d = (n_s0 > 4'd9) || (n_s1 > 4'd9) || (n_m0 > 4'd9) || (n_m1 > 4'd9);
              valid_d = 1'b1; busy_d = 1'b0;
            end else begin
              sec_d = sh_q;
            end
          end
        end
      end
      GAP: begin
        if (end_per) begin
          t_d = 1'b1; ce_d = 1'b1; io_oe_d = 1'b1; io_out_d = CMD_MIN[0];
        end
      end
      default: ;
    endcase
  end

  assign ce = ce_q;  assign sclk = sclk_q;  assign io_out = io_out_q;  assign io_oe = io_oe_q;
  assign busy = busy_q;  assign valid = valid_q;  assign ch = ch_q;  assign bcd_err = err_q;
  assign data_sec_0 = s0_q;  assign data_sec_1 = s1_q;
  assign data_min_0 = m0_q;  assign data_min_1 = m1_q;
endmodule

// File: doc/rtc_read.md
# rtc_read

Serial read engine for the 3-wire real-time-clock chip. On request it issues two single-byte read transactions, seconds (command 0x81) then minutes (command 0x83). It returns the four BCD digits on the same nibble ports the write engine consumes: data_sec_0, data_sec_1, data_min_0 and data_min_1. It sits beside the write engine on the shared ce/sclk/io pins and feeds the display and time-set logic downstream.

## Interface
- HALF, default 2: clk cycles per sclk half-period. Legal range is ≥2.
- CMD_SEC, default 8'h81: seconds read command.
- CMD_MIN, default 8'h83: minutes read command.
- clk  input  1  system clock; all logic uses the rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- start  input  1  read request; sampled only in IDLE.
- io_in  input  1  data returned from the RTC io pin.
- ce  output  1  chip enable to the RTC.
- sclk  output  1  serial clock to the RTC.
- io_out  output  1  data driven to the io pin.
- io_oe  output  1  io pin output enable; 1 means the block drives the pin.
- busy  output  1  high from start accept until completion.
- valid  output  1  one-cycle pulse when the output digits update.
- data_sec_0, data_sec_1, data_min_0, data_min_1  output  4 each  BCD digits; the _1 ports are the tens digits.
- ch  output  1  clock-halt bit (seconds bit 7) from the last read.
- bcd_err  output  1  set when any returned digit is greater than 9.

## Operation
- States:
  - IDLE: start=1 → CMD, transaction index t=0.
  - CMD: 8 sclk periods, command bits shifted out LSB first.
  - RD: 8 sclk periods, data bits captured LSB first.
  - GAP: ce low for 2·HALF cycles → CMD with t=1.
  - After RD with t=0 → GAP. After RD with t=1 → IDLE, outputs load.
- Command per transaction: t=0 sends CMD_SEC, t=1 sends CMD_MIN.
- sclk period structure: low phase of HALF cycles, then high phase of HALF cycles. The period count is 16 per transaction: 8 in CMD, 8 in RD.
- CMD: io_oe=1. io_out takes bit k of the command at the start of period k and holds through that period's high phase.
- RD: io_oe=0 from the start of period 8 (the falling edge after the 8th rising edge). io_out is then 0.
- Capture: io_in is sampled on the clk edge that drives sclk high in period 8+k. That sample is stored as bit k of the byte.
- Result mapping:
  - data_sec_0 = sec[3:0]
  - data_sec_1 = {1'b0, sec[6:4]}
  - ch = sec[7]
  - data_min_0 = min[3:0]
  - data_min_1 = {1'b0, min[6:4]}
  - min[7] is ignored.
- Output loading: all digit outputs, ch and bcd_err load together at completion. They hold their values until the next completion or reset.
- bcd_err = (any of the four output nibbles > 9).
- start while busy is ignored and is not queued. start held high in IDLE after completion launches a new read.

## Timing
- Reset (async, immediate) values: state IDLE; ce, sclk, io_out, io_oe, busy, valid and ch all 0; all digits 0; bcd_err 0; counters 0.
- All outputs are registered.
- Let E0 be the edge at which start is sampled high in IDLE.
- Cycles are counted after E0:
  - Cycles 1..32·HALF: transaction 0, ce=1.
  - Cycles 32·HALF+1..34·HALF: gap, ce=0, sclk=0.
  - Cycles 34·HALF+1..66·HALF: transaction 1, ce=1.
- At edge E(66·HALF):
  - ce, sclk and io_oe go 0.
  - Outputs load.
  - valid=1 for exactly one cycle.
  - busy falls.
- busy rises at E0. The earliest new start is sampled at E(66·HALF)+1.
- ce rises with sclk=0 and falls with sclk=0. sclk never toggles while ce=0.
- rstn low mid-transaction releases the bus immediately (ce=0, io_oe=0). No partial result is loaded. The next start runs a full sequence from t=0.

## Test plan
- Basic read: RTC model returns 0x59 and 0x12, start pulse, HALF=2 → valid at cycle 132; sec_1=5, sec_0=9, min_1=1, min_0=2, ch=0, bcd_err=0.
- Command decode: model captures io_out on sclk rising edges while io_oe=1 → bytes 0x81 then 0x83; ce low for exactly 4 cycles between them; io_oe=0 during all RD periods.
- Clock-halt bit: seconds byte 0xB0 → ch=1, sec_1=3, sec_0=0.
- Invalid BCD: minutes byte 0x7A → min_1=7, min_0=0xA, bcd_err=1. A following good read clears bcd_err.
- Start during busy: extra start pulses at cycles 10 and 100 → exactly one valid pulse, at cycle 132.
- Mid-transaction reset: rstn low at cycle 20 → ce, sclk, io_oe and digits are 0 immediately. After release, a new start completes with correct data and no stale bits.
